// File: rtl/region_grow_ctrl.sv
// Breadth-first 4-connected region grower: clears the output image, then marks
// every pixel reachable from the seed whose intensity stays within thresh of it.
module region_grow_ctrl #(
  parameter int ROWS   = 273,
  parameter int COLS   = 182,
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int QDEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [$clog2(ROWS)-1:0] seed_row,
  input  logic [$clog2(COLS)-1:0] seed_col,
  input  logic [DW-1:0]           thresh,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  input  logic [DW-1:0]           rd_data,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [DW-1:0]           wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [AW:0]             region_size
);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int NPIX = ROWS * COLS;
  localparam int VW   = $clog2(NPIX);
  localparam int QW   = $clog2(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEED, S_SEED_W, S_POP, S_NB, S_NB_W, S_DONE
  } state_t;

  state_t           state, nxt;
  logic [RW-1:0]    srow, cur_row, nb_row;
  logic [CW-1:0]    scol, cur_col, nb_col;
  logic [DW-1:0]    thr, seed_val;
  logic [AW-1:0]    clr_idx, seed_addr, nb_addr;
  logic [1:0]       k;
  logic             nb_in, nb_ok, accept, push, pop, qfull, seed_ok;
  logic [DW:0]      diff;
  logic [RW+CW-1:0] q [QDEPTH];
  logic [RW+CW-1:0] push_ent, qhead;
  logic [QW-1:0]    wp, rp;
  logic [QW:0]      qcnt;
  logic [NPIX-1:0]  visited;

  assign seed_ok   = ({1'b0, seed_row} < (RW+1)'(ROWS)) && ({1'b0, seed_col} < (CW+1)'(COLS));
  assign seed_addr = AW'(srow) * AW'(COLS) + AW'(scol);
  assign nb_addr   = AW'(nb_row) * AW'(COLS) + AW'(nb_col);
  assign qfull     = (qcnt == (QW+1)'(QDEPTH));
  assign qhead     = q[rp];
  assign push_ent  = (state == S_SEED_W) ? {srow, scol} : {nb_row, nb_col};

  // k: 0 up, 1 down, 2 left, 3 right; nb_in false at the image edges
  always_comb begin
    nb_row = cur_row;
    nb_col = cur_col;
    nb_in  = 1'b0;
    case (k)
      2'd0: begin nb_in = (cur_row != '0);             nb_row = cur_row - RW'(1); end
      2'd1: begin nb_in = (cur_row != RW'(ROWS - 1));  nb_row = cur_row + RW'(1); end
      2'd2: begin nb_in = (cur_col != '0);             nb_col = cur_col - CW'(1); end
      default: begin nb_in = (cur_col != CW'(COLS - 1)); nb_col = cur_col + CW'(1); end
    endcase
  end

  assign nb_ok  = nb_in && !visited[VW'(nb_addr)];
  assign diff   = (rd_data >= seed_val) ? ({1'b0, rd_data} - {1'b0, seed_val})
                                        : ({1'b0, seed_val} - {1'b0, rd_data});
  assign accept = (diff <= {1'b0, thr});

  always_ff @(posedge clk) begin
    if (rstn) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    push    = 1'b0;
    pop     = 1'b0;
    busy    = (state != S_IDLE) && (state != S_DONE);
    done    = (state == S_DONE);
    case (state)
      S_IDLE:   if (start) nxt = seed_ok ? S_CLEAR : S_DONE;
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_idx;
        if (clr_idx == AW'(NPIX - 1)) nxt = S_SEED;
      end
      S_SEED: begin
        rd_en   = 1'b1;
        rd_addr = seed_addr;
        nxt     = S_SEED_W;
      end
      S_SEED_W: begin
        wr_en   = 1'b1;
        wr_addr = seed_addr;
        wr_data = '1;
        push    = 1'b1;
        nxt     = S_POP;
      end
      S_POP: begin
        if (qcnt == '0) nxt = S_DONE;
        else begin
          pop = 1'b1;
          nxt = S_NB;
        end
      end
      S_NB: begin
        if (nb_ok) begin
          rd_en   = 1'b1;
          rd_addr = nb_addr;
          nxt     = S_NB_W;
        end else if (k == 2'd3) nxt = S_POP;
      end
      S_NB_W: begin
        if (accept && !qfull) begin
          push    = 1'b1;
          wr_en   = 1'b1;
          wr_addr = nb_addr;
          wr_data = '1;
        end
        nxt = (k == 2'd3) ? S_POP : S_NB;
      end
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      srow        <= '0;
      scol        <= '0;
      thr         <= '0;
      seed_val    <= '0;
      clr_idx     <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      k           <= '0;
      region_size <= '0;
      overflow    <= 1'b0;
      wp          <= '0;
      rp          <= '0;
      qcnt        <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          srow        <= seed_row;
          scol        <= seed_col;
          thr         <= thresh;
          overflow    <= 1'b0;
          region_size <= '0;
          clr_idx     <= '0;
          wp          <= '0;
          rp          <= '0;
          qcnt        <= '0;
        end
        S_CLEAR:  clr_idx <= clr_idx + AW'(1);
        S_SEED_W: begin
          seed_val    <= rd_data;
          region_size <= (AW+1)'(1);
        end
        S_POP: if (pop) begin
          cur_row <= qhead[RW+CW-1:CW];
          cur_col <= qhead[CW-1:0];
          k       <= '0;
        end
        S_NB:     if (!nb_ok) k <= k + 2'd1;
        S_NB_W: begin
          k <= k + 2'd1;
          // a full queue drops the pixel but it stays visited
          if (accept) begin
            if (qfull) overflow <= 1'b1;
            else       region_size <= region_size + (AW+1)'(1);
          end
        end
        default: ;
      endcase
      if (push) begin
        wp   <= wp + QW'(1);
        qcnt <= qcnt + (QW+1)'(1);
      end else if (pop) begin
        rp   <= rp + QW'(1);
        qcnt <= qcnt - (QW+1)'(1);
      end
    end
  end

  // Storage without reset: CLEAR rewrites the bitmap before every use
  always_ff @(posedge clk) begin
    if (!rstn) begin
      if (state == S_CLEAR)       visited[VW'(clr_idx)]   <= 1'b0;
      else if (state == S_SEED_W) visited[VW'(seed_addr)] <= 1'b1;
      else if (state == S_NB_W)   visited[VW'(nb_addr)]   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn && push) q[wp] <= push_ent;
  end
endmodule
